// File: rtl/sram_ctrl_pkg.sv
// Shared types and timing defaults for the synchronous SRAM bus initiator.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_TURN
    } state_t;

    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int DEF_TURN_CYC  = 1;

    function automatic int cnt_width(input int s, input int p, input int h, input int t);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        if (t > m) m = t;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_SETUP_CYC, DEF_PULSE_CYC, DEF_HOLD_CYC, DEF_TURN_CYC);

endpackage

// File: rtl/sram_bus_ctrl.sv
// Sequences req/ready transactions into timed nCS/nWE/nOE SRAM cycles.
// Every pin, including the data drive enable, is a flop loaded from the next state.
module sram_bus_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW        = 4,
    parameter int DW        = 4,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int TURN_CYC  = DEF_TURN_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          nCS,
    output logic          nWE,
    output logic          nOE,
    output logic [AW-1:0] A,
    inout  wire  [DW-1:0] D
);

    localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC, TURN_CYC);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] TURN_LD  = CW'(TURN_CYC - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            pending;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            drive_en;
    logic            accept;
    logic            last;
    logic            capture;
    logic            bus_nx;
    logic            strobe_nx;

    // pending covers the cycle between accept and SETUP, so no pin depends on req
    assign ready   = (state == ST_IDLE) && !pending;
    assign accept  = req && ready;
    assign last    = (cnt == '0);
    assign capture = (state == ST_PULSE) && last && !we_q;

    assign A = addr_q;
    assign D = drive_en ? wdata_q : {DW{1'bz}};

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - CW'(1);
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (pending) begin
                    state_nx = ST_SETUP;
                    cnt_nx   = SETUP_LD;
                end
            end
            ST_SETUP: if (last) begin
                state_nx = ST_PULSE;
                cnt_nx   = PULSE_LD;
            end
            ST_PULSE: if (last) begin
                state_nx = ST_HOLD;
                cnt_nx   = HOLD_LD;
            end
            ST_HOLD: if (last) begin
                state_nx = we_q ? ST_IDLE : ST_TURN;
                cnt_nx   = we_q ? '0 : TURN_LD;
            end
            ST_TURN: if (last) begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
        bus_nx    = (state_nx == ST_SETUP) || (state_nx == ST_PULSE) || (state_nx == ST_HOLD);
        strobe_nx = (state_nx == ST_PULSE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pending <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            nCS      <= 1'b1;
            nWE      <= 1'b1;
            nOE      <= 1'b1;
            drive_en <= 1'b0;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            nCS      <= !bus_nx;
            nWE      <= !(strobe_nx && we_q);
            nOE      <= !(strobe_nx && !we_q);
            drive_en <= bus_nx && we_q;
            rvalid   <= capture;
            // raw bus value, so an undriven or contended bus is visible downstream
            if (capture) rdata <= D;
        end
    end

endmodule
